// File: rtl/cam_capture_decim_pkg.sv
// Shared types and constants for the camera capture / decimation front end:
// capture FSM states, default frame geometry and the RGB565 field layout.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_VS    = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_HI         = 2'd2,
        ST_LO         = 2'd3
    } cap_state_e;

    localparam int DEF_SRC_W     = 640;
    localparam int DEF_SRC_H     = 480;
    localparam int DEF_DEC_SHIFT = 2;
    localparam int DEF_FB_W      = 160;
    localparam int DEF_FB_H      = 120;
    localparam int DEF_ADDR_W    = 15;

    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    // The camera sends the high byte first: RRRRRGGG then GGGBBBBB.
    function automatic logic [15:0] rgb565_pack(input logic [7:0] hi_byte,
                                                input logic [7:0] lo_byte);
        logic [15:0] pix;
        pix = 16'h0000;
        pix[RGB_R_MSB:RGB_R_LSB] = hi_byte[7:3];
        pix[RGB_G_MSB:RGB_G_LSB] = {hi_byte[2:0], lo_byte[7:5]};
        pix[RGB_B_MSB:RGB_B_LSB] = lo_byte[4:0];
        return pix;
    endfunction

endpackage

// File: rtl/cam_capture_decim_if.sv
// Frame-buffer write port bundle: write strobe, address, pixel data and the
// end-of-frame pulse. The capture block is the master.
interface cam_capture_decim_if #(
    parameter int ADDR_W = cam_pkg::DEF_ADDR_W
) ();

    logic              fb_we;
    logic [ADDR_W-1:0] fb_waddr;
    logic [15:0]       fb_wdata;
    logic              frame_done;

    modport master (
        output fb_we,
        output fb_waddr,
        output fb_wdata,
        output frame_done
    );

    modport slave (
        input fb_we,
        input fb_waddr,
        input fb_wdata,
        input frame_done
    );

endinterface

// File: rtl/cam_capture_decim_sync_edge.sv
// Two-flop synchroniser for an asynchronous camera control pin, plus one
// delay flop so rising/falling edges can be detected in the clk domain.
module cam_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic dly_r;

    // Synchroniser chain followed by the edge-detect delay stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            dly_r  <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            dly_r  <= sync_r;
        end
    end

    assign sync = sync_r;
    assign rise = sync_r & ~dly_r;
    assign fall = ~sync_r & dly_r;

endmodule

// File: rtl/cam_capture_decim.sv
// Camera capture front end: samples the OV7670 pins in the system clock
// domain, pairs bytes into RGB565 pixels, tracks source row/column and
// emits decimated single-cycle writes into a linear frame buffer.
module cam_capture_decim
    import cam_pkg::*;
#(
    parameter int SRC_W     = DEF_SRC_W,
    parameter int SRC_H     = DEF_SRC_H,
    parameter int DEC_SHIFT = DEF_DEC_SHIFT,
    parameter int FB_W      = DEF_FB_W,
    parameter int FB_H      = DEF_FB_H,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cam_pclk,
    input  logic                cam_href,
    input  logic                cam_vsync,
    input  logic [7:0]          cam_data,
    input  logic                enable,
    cam_capture_decim_if.master fb,
    output logic [9:0]          row,
    output logic [9:0]          col
);

    localparam logic [9:0]        SRC_W_L = 10'(SRC_W);
    localparam logic [9:0]        SRC_H_L = 10'(SRC_H);
    localparam logic [ADDR_W-1:0] FB_W_L  = ADDR_W'(FB_W);

    // FB_H is implied by SRC_H >> DEC_SHIFT; the row limit enforces it.
    logic [31:0] unused_fb_h_s;
    assign unused_fb_h_s = 32'(FB_H);

    cap_state_e state_r;
    cap_state_e state_nx;

    logic       pclk_sync_s;
    logic       pclk_rise_s;
    logic       pclk_fall_s;
    logic       href_sync_s;
    logic       href_rise_s;
    logic       href_fall_s;
    logic       vs_sync_s;
    logic       vs_rise_s;
    logic       vs_fall_s;
    logic       unused_edges_s;

    logic [7:0] data_q1_r;
    logic [7:0] data_q2_r;
    logic [7:0] data_q3_r;
    logic [7:0] hi_byte_r;

    logic       latch_hi_s;
    logic       pix_done_s;
    logic       line_end_s;
    logic       frame_end_s;
    logic       clr_pos_s;

    logic [9:0]        x_s;
    logic [9:0]        y_s;
    logic [ADDR_W-1:0] addr_s;
    logic              wr_ok_s;

    cam_sync_edge u_sync_pclk (
        .clk   (clk),
        .reset (reset),
        .din   (cam_pclk),
        .sync  (pclk_sync_s),
        .rise  (pclk_rise_s),
        .fall  (pclk_fall_s)
    );

    cam_sync_edge u_sync_href (
        .clk   (clk),
        .reset (reset),
        .din   (cam_href),
        .sync  (href_sync_s),
        .rise  (href_rise_s),
        .fall  (href_fall_s)
    );

    cam_sync_edge u_sync_vsync (
        .clk   (clk),
        .reset (reset),
        .din   (cam_vsync),
        .sync  (vs_sync_s),
        .rise  (vs_rise_s),
        .fall  (vs_fall_s)
    );

    assign unused_edges_s = pclk_sync_s ^ pclk_fall_s ^ href_rise_s;

    // Data bus gets one more stage than the controls so the byte presented
    // with pclk_rise is the one that was stable before the PCLK edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q1_r <= 8'h00;
            data_q2_r <= 8'h00;
            data_q3_r <= 8'h00;
        end else begin
            data_q1_r <= cam_data;
            data_q2_r <= data_q1_r;
            data_q3_r <= data_q2_r;
        end
    end

    // Capture FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_WAIT_VS;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next state and event decode; frame end beats line end beats a byte.
    always_comb begin
        state_nx    = state_r;
        latch_hi_s  = 1'b0;
        pix_done_s  = 1'b0;
        line_end_s  = 1'b0;
        frame_end_s = 1'b0;
        case (state_r)
            ST_WAIT_VS: begin
                if (vs_sync_s) begin
                    state_nx = ST_WAIT_FRAME;
                end else begin
                    state_nx = ST_WAIT_VS;
                end
            end
            ST_WAIT_FRAME: begin
                if (vs_fall_s) begin
                    state_nx = enable ? ST_HI : ST_WAIT_VS;
                end else begin
                    state_nx = ST_WAIT_FRAME;
                end
            end
            ST_HI, ST_LO: begin
                if (vs_rise_s) begin
                    frame_end_s = 1'b1;
                    state_nx    = ST_WAIT_FRAME;
                end else if (href_fall_s) begin
                    line_end_s = 1'b1;
                    state_nx   = ST_HI;
                end else if (pclk_rise_s && href_sync_s) begin
                    if (state_r == ST_HI) begin
                        latch_hi_s = 1'b1;
                        state_nx   = ST_LO;
                    end else begin
                        pix_done_s = 1'b1;
                        state_nx   = ST_HI;
                    end
                end else begin
                    state_nx = state_r;
                end
            end
            default: begin
                state_nx = ST_WAIT_VS;
            end
        endcase
        clr_pos_s = (state_nx == ST_WAIT_FRAME) && (state_r != ST_WAIT_FRAME);
    end

    // Decimated write qualification and linear address for the current pixel.
    always_comb begin
        x_s     = col >> DEC_SHIFT;
        y_s     = row >> DEC_SHIFT;
        addr_s  = (ADDR_W'(y_s) * FB_W_L) + ADDR_W'(x_s);
        wr_ok_s = (col < SRC_W_L) && (row < SRC_H_L) &&
                  (col[DEC_SHIFT-1:0] == '0) && (row[DEC_SHIFT-1:0] == '0);
    end

    // Position counters, byte pairing and registered frame-buffer outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_byte_r     <= 8'h00;
            row           <= 10'd0;
            col           <= 10'd0;
            fb.fb_we      <= 1'b0;
            fb.fb_waddr   <= '0;
            fb.fb_wdata   <= 16'h0000;
            fb.frame_done <= 1'b0;
        end else begin
            fb.fb_we      <= 1'b0;
            fb.frame_done <= frame_end_s;
            if (latch_hi_s) begin
                hi_byte_r <= data_q3_r;
            end
            if (clr_pos_s) begin
                row <= 10'd0;
                col <= 10'd0;
            end else if (line_end_s) begin
                col <= 10'd0;
                row <= (row == SRC_H_L) ? row : row + 10'd1;
            end else if (pix_done_s) begin
                col <= (col == SRC_W_L) ? col : col + 10'd1;
                if (wr_ok_s) begin
                    fb.fb_we    <= 1'b1;
                    fb.fb_waddr <= addr_s;
                    fb.fb_wdata <= rgb565_pack(hi_byte_r, data_q3_r);
                end
            end
        end
    end

endmodule
